// File: rtl/hamming_decoder_engine.sv
// (16,11) SECDED decoder: reads NUM_WORDS codewords, corrects single errors, writes message + 2-bit flag back.
// Latency: 6 cycles per word, done 6*NUM_WORDS+1 cycles after an accepted start; start outside IDLE ignored.
// Backpressure: none, fixed-rate memory master. HAMMING_STATS_EN builds the single/double error counters.
module hamming_decoder_engine #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_wen,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [5:0] single_cnt,
    output logic [5:0] double_cnt
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q;
    logic [15:0] code_q;
    logic [10:0] msg_q;
    logic [1:0]  flag_q;
    logic        done_q;

    logic [3:0]  syn;
    logic        par;
    logic [15:0] fixed;
    logic [10:0] dec_msg;
    logic [1:0]  dec_flag;
    logic        last_word;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;

    function automatic logic [3:0] calc_syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) s = s ^ 4'(k);
        end
        return s;
    endfunction

    // Data bits sit at positions 15..9, 7..5 and 3; the rest are parity.
    function automatic logic [10:0] data_bits(input logic [15:0] w);
        return {w[15:9], w[7:5], w[3]};
    endfunction

    always_comb begin
        syn      = calc_syndrome(code_q);
        par      = ^code_q;
        fixed    = code_q;
        dec_flag = 2'b00;
        if (par) begin
            fixed    = code_q ^ (16'd1 << syn);
            dec_flag = 2'b01;
        end else if (syn != 4'd0) begin
            dec_flag = 2'b10;
        end
        dec_msg = data_bits(fixed);
    end

    assign src_addr  = 8'(SRC_BASE) + {1'b0, idx_q, 1'b0};
    assign dst_addr  = 8'(DST_BASE) + {1'b0, idx_q, 1'b0};
    assign last_word = (idx_q == 6'(NUM_WORDS - 1));
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        mem_addr  = 8'd0;
        mem_wen   = 1'b0;
        mem_wdata = 8'd0;
        case (state_q)
            IDLE:   if (start) state_d = RD_LO;
            RD_LO: begin
                mem_addr = src_addr;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = src_addr + 8'd1;
                state_d  = CAP_HI;
            end
            CAP_HI: state_d = DECODE;
            DECODE: state_d = WR_LO;
            WR_LO: begin
                mem_wen   = 1'b1;
                mem_addr  = dst_addr;
                mem_wdata = msg_q[7:0];
                state_d   = WR_HI;
            end
            WR_HI: begin
                mem_wen   = 1'b1;
                mem_addr  = dst_addr + 8'd1;
                mem_wdata = {flag_q, 3'b000, msg_q[10:8]};
                state_d   = last_word ? FIN : RD_LO;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            msg_q   <= '0;
            flag_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q  <= '0;
                        done_q <= 1'b0;
                    end
                end
                RD_HI:  code_q[7:0]  <= mem_rdata;
                CAP_HI: code_q[15:8] <= mem_rdata;
                DECODE: begin
                    msg_q  <= dec_msg;
                    flag_q <= dec_flag;
                end
                WR_HI: begin
                    if (last_word) done_q <= 1'b1;
                    else           idx_q  <= idx_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAMMING_STATS_EN
    logic [5:0] single_q;
    logic [5:0] double_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            single_q <= '0;
            double_q <= '0;
        end else if (state_q == IDLE && start) begin
            single_q <= '0;
            double_q <= '0;
        end else if (state_q == DECODE) begin
            if (dec_flag == 2'b01 && single_q != 6'd63) single_q <= single_q + 6'd1;
            if (dec_flag == 2'b10 && double_q != 6'd63) double_q <= double_q + 6'd1;
        end
    end

    assign single_cnt = single_q;
    assign double_cnt = double_q;
`else
    assign single_cnt = 6'd0;
    assign double_cnt = 6'd0;
`endif

endmodule

// File: tb/tb_hamming_decoder_engine.sv
// Bench for hamming_decoder_engine: directed vector table plus randomized runs against an encoder-based model.
module tb_hamming_decoder_engine;
    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'd0;
    logic [5:0] single_cnt;
    logic [5:0] double_cnt;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       ld_req = 1'b0;
    int         wr_total = 0;

    typedef struct {
        logic [10:0] msg;
        logic [15:0] flip;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;

    vec_t        tbl [NW];
    logic [15:0] code_a [NW];
    logic [7:0]  exp_lo [NW];
    logic [7:0]  exp_hi [NW];
    int          exp_single;
    int          exp_double;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    hamming_decoder_engine #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .single_cnt(single_cnt), .double_cnt(double_cnt)
    );

    always @(posedge clk) begin
        if (ld_req) mem <= img;
        else if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (mem_wen) wr_total <= wr_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Classic Hamming encoder: each power-of-two parity covers positions sharing that index bit.
    function automatic logic [15:0] encode(input logic [10:0] m);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 11; k++) w[DPOS[k]] = m[k];
        for (int p = 1; p < 16; p = p * 2) begin
            logic b;
            b = 1'b0;
            for (int j = 1; j < 16; j++) if ((j & p) != 0) b = b ^ w[j];
            w[p] = b;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        logic [10:0] m;
        for (int k = 0; k < 11; k++) m[k] = w[DPOS[k]];
        return m;
    endfunction

    task automatic make_word(input int i, input logic [10:0] m, input int kind);
        logic [15:0] c;
        logic [10:0] mm;
        int b1, b2;
        c = encode(m);
        exp_lo[i] = m[7:0];
        exp_hi[i] = {5'b00000, m[10:8]};
        if (kind == 1) begin
            b1 = $urandom_range(0, 15);
            c[b1] = ~c[b1];
            exp_hi[i] = {2'b01, 3'b000, m[10:8]};
            exp_single++;
        end else if (kind == 2) begin
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            c[b1] = ~c[b1];
            c[b2] = ~c[b2];
            mm = extract(c);
            exp_lo[i] = mm[7:0];
            exp_hi[i] = {2'b10, 3'b000, mm[10:8]};
            exp_double++;
        end
        code_a[i] = c;
    endtask

    task automatic random_words();
        exp_single = 0;
        exp_double = 0;
        for (int i = 0; i < NW; i++) make_word(i, 11'($urandom), $urandom_range(0, 2));
    endtask

    task automatic load_image();
        for (int a = 0; a < 256; a++) img[a] = 8'hEE;
        for (int i = 0; i < NW; i++) begin
            img[SRC + 2 * i]     = code_a[i][7:0];
            img[SRC + 2 * i + 1] = code_a[i][15:8];
        end
        @(negedge clk) ld_req = 1'b1;
        @(negedge clk) ld_req = 1'b0;
    endtask

    task automatic check_counts(input string tag);
`ifdef HAMMING_STATS_EN
        check({tag, "_single_cnt"}, 32'(single_cnt), 32'(exp_single));
        check({tag, "_double_cnt"}, 32'(double_cnt), 32'(exp_double));
`else
        check({tag, "_single_cnt"}, 32'(single_cnt), 32'd0);
        check({tag, "_double_cnt"}, 32'(double_cnt), 32'd0);
`endif
    endtask

    task automatic run_and_check(input string tag, input int pulse_at);
        int w0, ncyc;
        w0 = wr_total;
        ncyc = 0;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start = (n == pulse_at);
            if (done) begin
                ncyc = n;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(ncyc), 32'(6 * NW + 1));
        check({tag, "_writes"}, 32'(wr_total - w0), 32'(2 * NW));
        for (int i = 0; i < NW; i++) begin
            check($sformatf("%s_w%0d_lo", tag, i), 32'(mem[DST + 2 * i]), 32'(exp_lo[i]));
            check($sformatf("%s_w%0d_hi", tag, i), 32'(mem[DST + 2 * i + 1]), 32'(exp_hi[i]));
        end
        check_counts(tag);
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, 32'(done), 32'd1);
        check({tag, "_idle_wen"}, 32'(mem_wen), 32'd0);
    endtask

    initial begin
        int w_rst;

        for (int i = 0; i < NW; i++) tbl[i] = '{11'h5A3, 16'h0000, 8'hA3, 8'h05};
        tbl[0].flip = 16'h1000; tbl[0].exp_hi = 8'h45;
        tbl[3].flip = 16'h0001; tbl[3].exp_hi = 8'h45;
        tbl[7].flip = 16'h0408; tbl[7].exp_lo = 8'h82; tbl[7].exp_hi = 8'h85;

        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_single", 32'(single_cnt), 32'd0);
        check("rst_double", 32'(double_cnt), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Error-free run of the reference message.
        for (int i = 0; i < NW; i++) begin
            code_a[i] = encode(tbl[i].msg);
            exp_lo[i] = 8'hA3;
            exp_hi[i] = 8'h05;
        end
        exp_single = 0;
        exp_double = 0;
        load_image();
        run_and_check("clean", 0);

        // Directed errors, with a stray start pulse mid-run.
        for (int i = 0; i < NW; i++) begin
            code_a[i] = encode(tbl[i].msg) ^ tbl[i].flip;
            exp_lo[i] = tbl[i].exp_lo;
            exp_hi[i] = tbl[i].exp_hi;
        end
        exp_single = 2;
        exp_double = 1;
        load_image();
        run_and_check("table", 40);

        // Reset during word 3's read phase.
        random_words();
        load_image();
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("arst_wen", 32'(mem_wen), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", 32'(mem_wdata), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_prior_writes", 32'(wr_total), 32'(wr_total));
        w_rst = wr_total;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_writes", 32'(wr_total - w_rst), 32'd0);
        check("arst_done_after", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("arst_w%0d_lo", i), 32'(mem[DST + 2 * i]), 32'(exp_lo[i]));
            check($sformatf("arst_w%0d_hi", i), 32'(mem[DST + 2 * i + 1]), 32'(exp_hi[i]));
        end
        check("arst_w3_lo_untouched", 32'(mem[DST + 6]), 32'hEE);
        check("arst_w3_hi_untouched", 32'(mem[DST + 7]), 32'hEE);

        // Fresh runs after the abort, on randomized codewords.
        for (int r = 0; r < 3; r++) begin
            random_words();
            load_image();
            run_and_check($sformatf("rand%0d", r), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hamming_decoder_engine.md
Name: hamming_decoder_engine

Overview:
- Hardware decode engine for the (16,11) SECDED Hamming code produced by the program-1 encoder flow.
- Reads NUM_WORDS encoded 16-bit words from data memory, computes syndrome and overall parity, and corrects single-bit errors.
- Writes the 11-bit message plus a 2-bit status flag back to memory.
- Sits beside top_level's data memory as a second master; start/done handshake toward the controller.

Parameters:
- NUM_WORDS, 15, number of codewords processed per run (1..64)
- SRC_BASE, 30, byte address of first encoded word (low byte; high byte at +1)
- DST_BASE, 0, byte address of first decoded word (low byte; high byte at +1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a run
- done  output  1  high when run complete; held until next accepted start
- mem_addr  output  8  byte address to data memory
- mem_wen  output  1  write enable, one byte per cycle
- mem_wdata  output  8  write data
- mem_rdata  input  8  read data, valid one cycle after mem_addr (synchronous read)
- single_cnt  output  6  count of words with a corrected single error
- double_cnt  output  6  count of words with an uncorrectable double error

Behaviour:
- Reset (reset==0, asynchronous): FSM to IDLE. done=0, mem_wen=0, mem_addr=0, mem_wdata=0, counters=0, word index=0.
- Codeword bit layout, bit 15 down to bit 0: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - Word i low byte at SRC_BASE+2i; high byte at SRC_BASE+2i+1.
- FSM states: IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, FIN.
  - IDLE: on start=1, go to RD_LO. Clear done, index, and counters.
  - RD_LO: mem_addr=SRC_BASE+2i.
  - RD_HI: mem_addr=SRC_BASE+2i+1; capture mem_rdata as low byte.
  - CAP_HI: capture high byte.
  - DECODE: register syndrome, parity, corrected word, and flags.
  - WR_LO: mem_wen=1, mem_addr=DST_BASE+2i, mem_wdata=d8..d1.
  - WR_HI: mem_wen=1, mem_addr=DST_BASE+2i+1, mem_wdata={F1,F0,3'b000,d11,d10,d9}.
    - If i==NUM_WORDS-1, go to FIN; else i++ and go to RD_LO.
  - FIN: done=1, go to IDLE. done stays high in IDLE.
- Timing: exactly 6 cycles per word. done rises 6*NUM_WORDS+1 cycles after the start cycle (91 for defaults).
- mem_wen is high only in WR_LO and WR_HI.
- Decode rules:
  - S[3:0] = XOR of the indices of all set bits in positions 1..15.
  - P = XOR of all 16 bits.
  - S==0, P==0: F=00, data as-is.
  - P==1: single error at position S (S==0 means p0 flipped). Invert that bit, F=01, single_cnt++.
  - S!=0, P==0: double error. F=10, data uncorrected, double_cnt++.
- start while not in IDLE is ignored. start coincident with done held high starts a new run.
- Counters saturate at 63.
- Reset mid-run aborts immediately; no further writes occur, and memory already written is left intact.

Optional Feature:
- Macro HAMMING_STATS_EN.
- Defined: single_cnt and double_cnt count as described.
- Undefined: counter registers are not built; both ports are tied to 0. Decode, flags, and timing are unchanged.

Test Plan:
- All 15 words error-free (e.g. message 11'h5A3 encoded correctly) -> each high byte = {2'b00,3'b0,3'b101}, low byte = 8'hA3. done after 91 cycles. Counters 0/0.
- Word 0 has bit 12 (d8) flipped -> S=12, P=1, output corrected message, F=01, single_cnt=1.
- Word 3 has only p0 flipped -> S=0, P=1, F=01, data unchanged.
- Word 7 has bits 3 and 10 flipped -> S=9, P=0, F=10, data written uncorrected, double_cnt=1.
- Assert reset low at cycle 20 of a run:
  - Outputs zero asynchronously.
  - No mem_wen afterwards.
  - Words 0..2 already written remain; word 3 is not written.
  - A new start produces a full correct run.
- Pulse start again at cycle 40 of a run -> ignored. done at cycle 91; exactly 30 write cycles observed.
